// File: rtl/tpose_buf_ctrl.sv
// tpose_buf_ctrl: ping-pong transpose buffer controller for an external
// registered-output dual-port RAM. Rows of a 2^BLK_LOG2 x 2^BLK_LOG2 block are
// written in raster order into one bank while the other bank is read out.
// Build option: define TPOSE_TRANSPOSE_EN for column-major read-out; left
// undefined, the controller is a plain row-major ping-pong buffer.
module tpose_buf_ctrl #(
  parameter  int unsigned BLK_LOG2 = 3,
  localparam int unsigned CW       = 2 * BLK_LOG2,
  localparam int unsigned AW       = CW + 1
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          i_valid,
  output logic          i_ready,
  output logic          o_valid,
  input  logic          o_ready,
  output logic          o_last,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic          mem_re,
  output logic [AW-1:0] mem_raddr
);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          wbank_q, wbank_d;
  logic          rbank_q, rbank_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [1:0]    full_q, full_d;
  logic          o_valid_q, o_valid_d;
  logic          o_last_q, o_last_d;

  logic          w_last;
  logic          r_last;

  assign w_last = (wcnt_q == CNT_MAX);
  assign r_last = (rcnt_q == CNT_MAX);

  // Memory-side handshakes and addresses; reset masks both enables.
  always_comb begin
    i_ready   = n_rst & ~full_q[wbank_q];
    mem_we    = i_valid & i_ready;
    mem_waddr = {wbank_q, wcnt_q};
    // A held, unconsumed sample blocks the next read so dout is not overwritten.
    mem_re    = n_rst & full_q[rbank_q] & (~o_valid_q | o_ready);
`ifdef TPOSE_TRANSPOSE_EN
    // Swapping the row/column halves of the count walks the block by columns.
    mem_raddr = {rbank_q, rcnt_q[BLK_LOG2-1:0], rcnt_q[CW-1:BLK_LOG2]};
`else
    mem_raddr = {rbank_q, rcnt_q};
`endif
  end

  // Write side: advance the fill count and hand the bank over when it is full.
  always_comb begin
    wbank_d = wbank_q;
    wcnt_d  = wcnt_q;
    if (mem_we) begin
      wcnt_d = wcnt_q + CNT_ONE;
      if (w_last) begin
        wbank_d = ~wbank_q;
      end
    end
  end

  // Read side: advance the drain count and release the bank after its last sample.
  always_comb begin
    rbank_d = rbank_q;
    rcnt_d  = rcnt_q;
    if (mem_re) begin
      rcnt_d = rcnt_q + CNT_ONE;
      if (r_last) begin
        rbank_d = ~rbank_q;
      end
    end
  end

  // Bank ownership: fill and release can coincide but always hit different banks.
  always_comb begin
    full_d = full_q;
    if (mem_we && w_last) begin
      full_d[wbank_q] = 1'b1;
    end
    if (mem_re && r_last) begin
      full_d[rbank_q] = 1'b0;
    end
  end

  // Output qualifiers track the registered RAM output one cycle behind mem_re.
  always_comb begin
    o_valid_d = o_valid_q;
    o_last_d  = o_last_q;
    if (mem_re) begin
      o_valid_d = 1'b1;
      o_last_d  = r_last;
    end else if (o_ready) begin
      o_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wbank_q   <= 1'b0;
      rbank_q   <= 1'b0;
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      full_q    <= '0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
    end else begin
      wbank_q   <= wbank_d;
      rbank_q   <= rbank_d;
      wcnt_q    <= wcnt_d;
      rcnt_q    <= rcnt_d;
      full_q    <= full_d;
      o_valid_q <= o_valid_d;
      o_last_q  <= o_last_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_last  = o_last_q;

endmodule

// File: tb/tb_tpose_buf_ctrl.sv
// Bench for tpose_buf_ctrl: a vector table for reset/write-address behaviour,
// then streamed block sequences checked against a RAM model and scoreboard.
module tb_tpose_buf_ctrl;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       i_valid = 1'b0;
  logic       o_ready = 1'b1;
  logic       i_ready, o_valid, o_last, mem_we, mem_re;
  logic [6:0] mem_waddr, mem_raddr;

  int checks = 0;
  int errors = 0;
  int wk = 0;
  int rk = 0;
  int ok = 0;
  int epoch = 1;

  logic [15:0] mem [128];
  logic [15:0] dout = '0;
  logic [15:0] wdata;

  assign wdata = 16'(epoch * 4096 + wk);

  tpose_buf_ctrl #(.BLK_LOG2(3)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_last    (o_last),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_re    (mem_re),
    .mem_raddr (mem_raddr)
  );

  always #5 clk = ~clk;

  // External dual-port RAM with registered read data held while re is low.
  always @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= wdata;
    if (mem_re) dout <= mem[mem_raddr];
  end

  // Transaction counters for writes, reads and consumed outputs.
  always @(posedge clk) begin
    if (!n_rst) begin
      wk <= 0;
      rk <= 0;
      ok <= 0;
    end else begin
      if (mem_we) wk <= wk + 1;
      if (mem_re) rk <= rk + 1;
      if (o_valid && o_ready) ok <= ok + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int exp_raddr(input int n);
    int r;
    int bank;
    r    = n % 64;
    bank = (n / 64) % 2;
`ifdef TPOSE_TRANSPOSE_EN
    return bank * 64 + (r % 8) * 8 + r / 8;
`else
    return bank * 64 + r;
`endif
  endfunction

  function automatic int exp_data(input int n);
    int b;
    int j;
    int src;
    b = n / 64;
    j = n % 64;
`ifdef TPOSE_TRANSPOSE_EN
    src = (j % 8) * 8 + j / 8;
`else
    src = j;
`endif
    return epoch * 4096 + b * 64 + src;
  endfunction

  // Continuous monitor: addresses, output data order, last flag and stall hold.
  logic        prev_hold = 1'b0;
  logic [15:0] prev_dout = '0;
  logic        prev_last = 1'b0;
  always @(negedge clk) begin
    if (n_rst) begin
      if (prev_hold) begin
        chk("hold_valid", int'(o_valid), 1);
        chk("hold_data", int'(dout), int'(prev_dout));
        chk("hold_last", int'(o_last), int'(prev_last));
      end
      if (mem_we) chk("waddr", int'(mem_waddr), wk % 128);
      if (mem_re) chk("raddr", int'(mem_raddr), exp_raddr(rk));
      if (o_valid && o_ready) begin
        chk("dout", int'(dout), exp_data(ok));
        chk("o_last", int'(o_last), int'(ok % 64 == 63));
      end
      if (o_valid && !o_ready) chk("stall_no_re", int'(mem_re), 0);
    end
    prev_hold = n_rst && o_valid && !o_ready;
    prev_dout = dout;
    prev_last = o_last;
  end

  task automatic do_reset();
    n_rst   = 1'b0;
    i_valid = 1'b0;
    o_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    epoch++;
    n_rst = 1'b1;
  endtask

  // mode 0: always ready; 1: ready toggles 1,0,1,0; 2: not ready for 130 cycles.
  task automatic stream(input int nw, input int nout, input int mode);
    int w = 0;
    int c = 0;
    int ok0 = ok;
    int first_ov = -1;
    int last_ov = -1;
    int w64 = -1;
    int nov = 0;
    int drops = 0;
    int first_ra = -1;
    bit rel_pend = 1'b0;
    while ((w < nw || ok - ok0 < nout) && c < 2000) begin
      i_valid = (w < nw);
      case (mode)
        1:       o_ready = (c % 2 == 0);
        2:       o_ready = (c >= 130);
        default: o_ready = 1'b1;
      endcase
      @(negedge clk);
      if (rel_pend) begin
        chk("ready_after_release", int'(i_ready), 1);
        rel_pend = 1'b0;
      end
      if (mem_re && rk % 64 == 63 && !i_ready) rel_pend = 1'b1;
      if (w < nw && !i_ready) drops++;
      if (mem_re && first_ra < 0) first_ra = int'(mem_raddr);
      if (o_valid && first_ov < 0) first_ov = c;
      if (o_valid && o_ready) begin
        nov++;
        last_ov = c;
      end
      if (mode == 2 && c == 129) begin
        chk("both_full_irdy", int'(i_ready), 0);
        chk("both_full_writes", w, 128);
        chk("both_full_ovalid", int'(o_valid), 1);
      end
      if (mem_we) begin
        if (w == 63) w64 = c;
        w++;
      end
      @(posedge clk);
      #1;
      c++;
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    chk("stream_done", int'(c < 2000), 1);
    chk("out_count", ok - ok0, nout);
    if (mode == 0 && nw >= 64) chk("latency", first_ov - w64, 2);
    if (mode == 0 && nout > 0) begin
      chk("no_irdy_drop", drops, 0);
      chk("gap_free", last_ov - first_ov + 1, nov);
      chk("first_raddr", first_ra, 0);
    end
  endtask

  typedef struct {
    bit rst_n;
    bit iv;
    bit ordy;
    bit chk_reg;
    int e_irdy;
    int e_we;
    int e_waddr;
    int e_re;
    int e_ov;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 0, 0, 0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1, 1, 0, 0, 0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1, 1, 1, 0, 0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1, 0, 2, 0, 0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1, 1, 2, 0, 0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 3, 0, 0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1, 1, 0, 0, 0};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1, 1, 1, 0, 0};
    tbl[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 2, 0, 0};

    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      n_rst   = tbl[i].rst_n;
      i_valid = tbl[i].iv;
      o_ready = tbl[i].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d_i_ready", i), int'(i_ready), tbl[i].e_irdy);
      chk($sformatf("vec%0d_mem_we", i), int'(mem_we), tbl[i].e_we);
      chk($sformatf("vec%0d_mem_re", i), int'(mem_re), tbl[i].e_re);
      if (tbl[i].chk_reg) begin
        chk($sformatf("vec%0d_waddr", i), int'(mem_waddr), tbl[i].e_waddr);
        chk($sformatf("vec%0d_o_valid", i), int'(o_valid), tbl[i].e_ov);
      end
      @(posedge clk);
      #1;
    end

    do_reset();
    stream(64, 64, 0);
    do_reset();
    stream(192, 192, 0);
    do_reset();
    stream(192, 192, 2);
    do_reset();
    stream(64, 64, 1);
    do_reset();
    stream(30, 0, 0);
    do_reset();
    stream(64, 64, 0);

    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("idle_i_ready", int'(i_ready), 1);
    chk("idle_mem_re", int'(mem_re), 0);
    chk("idle_o_valid", int'(o_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/tpose_buf_ctrl.md
TPOSE_BUF_CTRL -- requirements
Module: tpose_buf_ctrl

Interface
REQ-001 Parameter: BLK_LOG2, default 3, log2 of block side; block = 2^(2*BLK_LOG2) samples (64); two banks; AW = 2*BLK_LOG2+1 (7).
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 n_rst  in  1  reset, synchronous, active-low.
REQ-004 i_valid  in  1  upstream sample present, raster order.
REQ-005 i_ready  out  1  controller accepts a sample this cycle.
REQ-006 o_valid  out  1  external dpram dout holds a valid sample.
REQ-007 o_ready  in  1  downstream consumes dout this cycle.
REQ-008 o_last  out  1  qualifies o_valid; final sample of a block.
REQ-009 mem_we  out  1  dpram write enable.
REQ-010 mem_waddr  out  AW  dpram write address.
REQ-011 mem_re  out  1  dpram read enable; dpram dout is registered and valid 1 cycle after re, held while re is low.
REQ-012 mem_raddr  out  AW  dpram read address.

Function
REQ-013 State: wbank, rbank (1b each); wcnt, rcnt (2*BLK_LOG2 b each); full[1:0]; o_valid, o_last registers.
REQ-014 i_ready = !full[wbank]; mem_we = i_valid & i_ready; mem_waddr = {wbank, wcnt}; all three combinational.
REQ-015 On each write: wcnt += 1; at wcnt = max: full[wbank] <= 1, wbank toggles, wcnt wraps to 0.
REQ-016 mem_re = full[rbank] & (!o_valid | o_ready), combinational; no read while a held sample is unconsumed.
REQ-017 mem_raddr = {rbank, rcnt[BLK_LOG2-1:0], rcnt[2*BLK_LOG2-1:BLK_LOG2]}: column-major read of row-major data.
REQ-018 On each read: rcnt += 1; at rcnt = max: full[rbank] <= 0, rbank toggles, rcnt wraps to 0.
REQ-019 o_valid next = mem_re ? 1 : (o_ready ? 0 : o_valid); o_last <= (rcnt = max) when mem_re, else held.
REQ-020 Write-side bank fill and read-side bank release in the same cycle both take effect; they always target different banks.
REQ-021 Latency: first sample of a block asserts o_valid 2 cycles after its 64th write is accepted; sustained throughput 1 sample/cycle on both ports.
REQ-022 Both banks full: i_ready = 0 until the read side releases a bank; i_ready is 1 in the cycle after the release edge.
REQ-023 Both banks empty: mem_re = 0; o_valid falls once the last held sample is consumed.

Reset
REQ-024 While n_rst = 0: wbank, rbank, wcnt, rcnt, full, o_valid, o_last <= 0; i_ready, mem_we, mem_re forced 0.
REQ-025 Reset mid-block discards all partially written and unread data; first write after reset goes to address 0.

Configuration
REQ-026 Macro TPOSE_TRANSPOSE_EN defined: mem_raddr per REQ-017.
REQ-027 Macro TPOSE_TRANSPOSE_EN undefined: mem_raddr = {rbank, rcnt} (row-major ping-pong); all other behaviour unchanged.

Verification
REQ-028 Reset, then 64 writes with i_valid=1 and o_ready=1 -> mem_waddr 0..63; mem_raddr sequence 0,8,16..56,1,9..63; o_last on 64th output.
REQ-029 Continuous 192 writes, o_ready=1 -> write banks 0,1,0; i_ready never drops; output gap-free at 1 sample/cycle after the first block.
REQ-030 o_ready=0 for 130 cycles while streaming -> both banks fill, i_ready=0 after write 128, mem_re=0 while o_valid=1; no sample lost after o_ready=1.
REQ-031 o_ready toggling 1,0,1,0 -> each sample presented exactly once, in order, held stable while o_ready=0.
REQ-032 n_rst=0 after 30 writes, then 64 writes -> first output address 0 of bank 0; no stale samples emitted.
REQ-033 Build without TPOSE_TRANSPOSE_EN, 64 writes -> mem_raddr 0..63 in order.
